// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access controller and memory block.
// Geometry constants, FSM state type, latched request bundle, load extension.
package mem_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } mem_state_t;

  typedef struct packed {
    logic              write;
    logic              byte_op;
    logic              sgn;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  function automatic logic [DATA_W-1:0] byte_extend(
    input logic [DATA_W-1:0] data,
    input logic              is_signed
  );
    return {{(DATA_W-8){is_signed & data[7]}}, data[7:0]};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Used for the load/store/fault access statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory initiator: turns a valid/ready request into a
// setup / one-cycle strobe / hold sequence, returns load data and stats.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_byte,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MEM_DEPTH);

  mem_state_t        state_q, state_d;
  mem_req_t          req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              mem_byte_q, mem_byte_d;

  logic in_fault;
  logic drive;
  logic hs;

  assign in_fault = ({1'b0, req_addr} >= DEPTH_L);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_d.write   = req_write;
          req_d.byte_op = req_byte;
          req_d.sgn     = req_signed;
          req_d.addr    = req_addr;
          req_d.wdata   = req_wdata;
          rdata_d       = '0;
          err_d         = in_fault;
          state_d       = in_fault ? RESP : SETUP;
        end
      end
      SETUP: state_d = STROBE;
      STROBE: begin
        if (!req_q.write) begin
          rdata_d = req_q.byte_op
                  ? byte_extend(mem_read_data, req_q.sgn)
                  : mem_read_data;
        end
        state_d = req_q.write ? HOLD : RESP;
      end
      HOLD: state_d = RESP;
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory pins come straight from flops, decoded from the next state,
  // so strobes and address never glitch on state decode.
  assign drive = (state_d == SETUP) || (state_d == STROBE)
              || (state_d == HOLD);

  always_comb begin
    mem_addr_d  = drive ? req_d.addr : '0;
    mem_wdata_d = drive ? req_d.wdata : '0;
    mem_byte_d  = drive & req_d.byte_op;
    mem_rd_d    = (state_d == STROBE) & ~req_d.write;
    mem_wr_d    = (state_d == STROBE) & req_d.write;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_byte_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_rd_q    <= mem_rd_d;
      mem_wr_q    <= mem_wr_d;
      mem_byte_q  <= mem_byte_d;
    end
  end

  assign req_ready  = rst_n & (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign resp_err   = resp_valid & err_q;

  assign mem_address    = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign mem_read       = mem_rd_q;
  assign mem_write      = mem_wr_q;
  assign mem_byte       = mem_byte_q;

  assign hs = resp_valid & resp_ready;

  sat_counter #(.CNT_W(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hs & ~err_q & ~req_q.write),
    .count (rd_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hs & ~err_q & req_q.write),
    .count (wr_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hs & err_q),
    .count (err_count)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-level timing model, attached
// word/byte memory, directed accesses with literal expectations.
module tb_mem_access_ctrl;

  localparam int CW = 2;
  localparam int SAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_byte = 1'b0;
  logic        req_signed = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  mem_address;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic        mem_byte;
  logic [31:0] mem_read_data;
  logic [CW-1:0] rd_count, wr_count, err_count;

  always #5 clk = ~clk;

  mem_access_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_byte(req_byte),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte(mem_byte), .mem_read_data(mem_read_data),
    .rd_count(rd_count), .wr_count(wr_count),
    .err_count(err_count)
  );

  // attached memory
  logic [31:0] mem [0:31] = '{default: '0};
  assign mem_read_data = mem[mem_address[4:0]];
  always @(posedge clk) begin
    if (mem_write) begin
      if (mem_byte)
        mem[mem_address[4:0]][7:0] <= mem_write_data[7:0];
      else
        mem[mem_address[4:0]] <= mem_write_data;
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ---- transaction-level model ----
  logic [31:0] ref_mem [0:31] = '{default: '0};
  bit          m_busy = 0;
  int          m_p = 0;
  int          m_lat = 0;
  bit          m_w = 0, m_b = 0, m_f = 0;
  logic [7:0]  m_a = '0;
  logic [31:0] m_d = '0, m_rd = '0;
  int          m_rc = 0, m_wc = 0, m_ec = 0;

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  function automatic logic [31:0] ld_val(input logic [31:0] w,
                                         input bit b, input bit s);
    if (!b) return w;
    if (s && w[7]) return w | 32'hFFFF_FF00;
    return w & 32'h0000_00FF;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0;
      m_p    <= 0;
      m_rc   <= 0;
      m_wc   <= 0;
      m_ec   <= 0;
    end else if (m_busy) begin
      if (m_p >= m_lat && resp_ready) begin
        m_busy <= 0;
        if (m_f) m_ec <= sat_inc(m_ec);
        else if (m_w) begin
          m_wc <= sat_inc(m_wc);
          ref_mem[m_a[4:0]] <= m_b
            ? {ref_mem[m_a[4:0]][31:8], m_d[7:0]} : m_d;
        end else m_rc <= sat_inc(m_rc);
      end else begin
        m_p <= m_p + 1;
      end
    end else if (req_valid) begin
      m_busy <= 1;
      m_p    <= 0;
      m_w    <= req_write;
      m_b    <= req_byte;
      m_a    <= req_addr;
      m_d    <= req_wdata;
      m_f    <= (req_addr >= 8'd32);
      m_lat  <= (req_addr >= 8'd32) ? 0 : (req_write ? 3 : 2);
      m_rd   <= (req_addr >= 8'd32 || req_write) ? 32'h0
              : ld_val(ref_mem[req_addr[4:0]], req_byte, req_signed);
    end
  end

  bit e_act, e_rsp;
  always @(negedge clk) begin
    e_act = m_busy && !m_f && (m_p < m_lat);
    e_rsp = m_busy && (m_p >= m_lat);
    chk("req_ready", 32'(req_ready), 32'(rst_n && !m_busy));
    chk("resp_valid", 32'(resp_valid), 32'(e_rsp));
    chk("resp_rdata", resp_rdata, e_rsp ? m_rd : 32'h0);
    chk("resp_err", 32'(resp_err), 32'(e_rsp && m_f));
    chk("mem_address", 32'(mem_address), e_act ? 32'(m_a) : 32'h0);
    chk("mem_wdata", mem_write_data, e_act ? m_d : 32'h0);
    chk("mem_byte", 32'(mem_byte), 32'(e_act && m_b));
    chk("mem_read", 32'(mem_read), 32'(e_act && m_p == 1 && !m_w));
    chk("mem_write", 32'(mem_write), 32'(e_act && m_p == 1 && m_w));
    chk("rd_count", 32'(rd_count), 32'(m_rc));
    chk("wr_count", 32'(wr_count), 32'(m_wc));
    chk("err_count", 32'(err_count), 32'(m_ec));
  end

  // ---- directed stimulus ----
  task automatic txn(input bit w, input bit b, input bit s,
                     input logic [7:0] a, input logic [31:0] d,
                     input int exp_lat, input logic [31:0] exp_rd,
                     input bit exp_err);
    int n;
    int strobes;
    logic [7:0] s_addr;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_byte = b;
    req_signed = s; req_addr = a; req_wdata = d;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0; strobes = 0; s_addr = '0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (mem_read || mem_write) begin
        strobes++;
        s_addr = mem_address;
      end
      if (resp_valid) break;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("rdata", resp_rdata, exp_rd);
    chk("err", 32'(resp_err), 32'(exp_err));
    chk("strobes", 32'(strobes), exp_err ? 32'd0 : 32'd1);
    if (!exp_err) chk("strobe_addr", 32'(s_addr), 32'(a));
    @(posedge clk);
    #1;
  endtask

  logic [31:0] held;
  int          k;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'h1);

    // word store then load
    txn(1, 0, 0, 8'd5, 32'hDEADBEEF, 4, 32'h0, 0);
    txn(0, 0, 0, 8'd5, 32'h0, 3, 32'hDEADBEEF, 0);
    chk("wr_count_1", 32'(wr_count), 32'd1);
    chk("rd_count_1", 32'(rd_count), 32'd1);

    // byte loads, sign vs zero extension
    txn(1, 0, 0, 8'd3, 32'h000000F0, 4, 32'h0, 0);
    txn(0, 1, 1, 8'd3, 32'h0, 3, 32'hFFFFFFF0, 0);
    txn(0, 1, 0, 8'd3, 32'h0, 3, 32'h000000F0, 0);
    // byte store only touches the low byte
    txn(1, 1, 0, 8'd3, 32'h12345681, 4, 32'h0, 0);
    txn(0, 1, 1, 8'd3, 32'h0, 3, 32'hFFFFFF81, 0);

    // faults and the depth boundary
    txn(0, 0, 0, 8'd40, 32'h0, 1, 32'h0, 1);
    chk("err_count_1", 32'(err_count), 32'd1);
    txn(1, 0, 0, 8'd32, 32'h11111111, 1, 32'h0, 1);
    txn(0, 0, 0, 8'd31, 32'h0, 3, 32'h0, 0);
    chk("err_count_2", 32'(err_count), 32'd2);

    // backpressure with a second request waiting
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0;
    req_signed = 1'b0; req_addr = 8'd5;
    @(posedge clk);
    #1 req_addr = 8'd3;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!resp_valid && k < 20);
    held = resp_rdata;
    chk("bp_first", held, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'h1);
      chk("bp_stable", resp_rdata, held);
      chk("bp_busy", 32'(req_ready), 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_gap", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_taken", 32'(req_ready), 32'h0);
    k = 1;
    while (!resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("bp_second_lat", 32'(k), 32'd3);
    chk("bp_second_data", resp_rdata, 32'h00000081);
    @(posedge clk);
    #1;

    // counter saturation
    for (int i = 0; i < 5; i++)
      txn(0, 0, 0, 8'd5, 32'h0, 3, 32'hDEADBEEF, 0);
    chk("rd_sat", 32'(rd_count), 32'h3);

    // reset in the middle of a store strobe
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b0;
    req_addr = 8'd7; req_wdata = 32'h55AA55AA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 chk("strobe_before_rst", 32'(mem_write), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_addr", 32'(mem_address), 32'h0);
    chk("rst_mem_wdata", mem_write_data, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_rd_count", 32'(rd_count), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 32'h1);
    chk("rel_wr_count", 32'(wr_count), 32'h0);
    chk("rel_err_count", 32'(err_count), 32'h0);
    txn(0, 0, 0, 8'd7, 32'h0, 3, 32'h0, 0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator for the data-memory interface (address / write_data / memRead / memWrite / byteOperations / read_data).
- Sits between the datapath load/store path and the memory block, and turns a valid/ready request into a glitch-safe strobe sequence:
  - address and data are set up one cycle before the strobe;
  - the strobe lasts exactly one cycle;
  - address and data are held one cycle after a write strobe.
- Returns word/byte load data with optional sign extension, flags out-of-range addresses, and keeps saturating access counters.

Parameters:
- ADDR_W, 8, width of request and memory address.
- DATA_W, 32, data width.
- MEM_DEPTH, 32, number of valid words; an address >= MEM_DEPTH is a fault.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle, can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte operation (low byte only), 0 = word.
- req_signed  in  1  byte load: 1 = sign-extend bit 7, 0 = zero-extend; ignored otherwise.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  DATA_W  load result; 0 for stores and faults.
- resp_err  out  1  address fault; no memory access was made.
- mem_address  out  ADDR_W  to memory address.
- mem_write_data  out  DATA_W  to memory write_data.
- mem_read  out  1  to memRead.
- mem_write  out  1  to memWrite.
- mem_byte  out  1  to byteOperations.
- mem_read_data  in  DATA_W  from memory read_data (combinational).
- rd_count, wr_count, err_count  out  CNT_W each  saturating counters of completed loads, stores and faults.

Behaviour:

Reset:
- Async reset forces all outputs to 0 immediately, including the strobes mid-operation. req_ready is also 0 while rst_n is low.
- After release: state IDLE, req_ready=1.

States: IDLE, SETUP, STROBE, HOLD, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write/byte/signed/addr/wdata.
  - If addr >= MEM_DEPTH, go to RESP with resp_err=1; otherwise go to SETUP.
- SETUP: drive mem_address, mem_write_data and mem_byte from the latch; strobes 0.
- STROBE:
  - Assert exactly one of mem_read or mem_write for this single cycle; address and data unchanged.
  - Load: capture mem_read_data at the end of this cycle. Word loads use the value as-is. Byte loads use bits [7:0], extended per req_signed.
  - Next state: HOLD for a store, RESP for a load.
- HOLD (stores only): strobes 0, address, data and mem_byte still held; next state RESP.
- RESP:
  - resp_valid=1 and resp_rdata/resp_err stable until resp_ready.
  - When resp_valid && resp_ready: go to IDLE and bump the matching counter.
  - mem_* outputs return to 0 outside SETUP/STROBE/HOLD.

Latency (handshake accepted at edge T):
- Fault: resp_valid at T+1.
- Load: mem_read high in cycle T+2, resp_valid at T+3.
- Store: mem_write high in cycle T+2, resp_valid at T+4.

Ordering and throughput:
- Maximum throughput is one access per 4 (load) or 5 (store) cycles.
- req_ready=0 in all states except IDLE, so requests are never overlapped. A request presented while busy is not accepted and must be held by the source.
- A response that has been accepted and a new request can occur in the same cycle only across two cycles: RESP→IDLE takes one edge, and no bypass is provided.

Invariants:
- mem_read and mem_write are never high together.
- mem_address never changes while either strobe is high, nor in the cycle after mem_write.

Counters:
- Increment by 1 on response handshake, saturate at all-ones, never wrap.
- A fault increments err_count only.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum mem_state_t (IDLE, SETUP, STROBE, HOLD, RESP);
  - the constants ADDR_W, DATA_W and MEM_DEPTH, which are shared with the memory block;
  - a function byte_extend(data, signed) returning DATA_W bits.
- Sub-module: sat_counter (parameter CNT_W; ports clk, rst_n, inc, count), instantiated three times.

Test Plan:
- Word store then load:
  - Store addr 5 data 32'hDEADBEEF gives mem_write high for exactly 1 cycle at T+2 with mem_address=5; resp at T+4, resp_err=0.
  - Loading addr 5 then returns 32'hDEADBEEF at T+3; wr_count=1, rd_count=1.
- Byte load, signed vs unsigned: memory word 32'h000000F0 at addr 3. req_signed=1 gives 32'hFFFFFFF0; req_signed=0 gives 32'h000000F0.
- Fault: load addr 8'd40 gives resp_valid at T+1, resp_err=1, resp_rdata=0, no strobe ever asserted; err_count=1.
- Backpressure: hold resp_ready=0 for 5 cycles. resp_valid and resp_rdata stay stable, req_ready=0, and a second req_valid is not accepted until one cycle after resp_ready.
- Reset mid-store: drop rst_n during STROBE. mem_write falls before the next clock edge, all outputs are 0, and after release req_ready=1 with the counters at 0.
- Saturation with CNT_W=2: 5 loads leave rd_count at 2'b11.
